bound_flasher_ctrl: RTL and testbench

- Control FSM that drives the 2-bit command bus of the 16-lamp shift datapath.
- Encoding: cmd=1 shifts a 1 in from the LSB (one more lamp on); cmd=2 shifts a 0 in from the MSB (one fewer lamp on); cmd=0 or 3 clears all lamps.
- Sequences the lamp bar through the bound-flasher pattern on a flick request, including kickback re-runs.
- Keeps an internal level counter that mirrors the datapath. Optionally checks the datapath's lamp bus against that counter.

---
 rtl/bf_pkg.sv | 28 ++
 rtl/bf_lamp_checker.sv | 27 ++
 rtl/bound_flasher_ctrl.sv | 97 +++++++++
 tb/tb_bound_flasher_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared command/state encodings for the bound-flasher controller and its lamp checker.
package bf_pkg;

  localparam int NUM_LAMPS_DEF = 16;

  localparam logic [1:0] CMD_CLEAR = 2'd0;
  localparam logic [1:0] CMD_ON    = 2'd1;
  localparam logic [1:0] CMD_OFF   = 2'd2;

  localparam logic [2:0] ST_IDLE_E = 3'd0;
  localparam logic [2:0] ST_UP1_E  = 3'd1;
  localparam logic [2:0] ST_DN1_E  = 3'd2;
  localparam logic [2:0] ST_UP2_E  = 3'd3;
  localparam logic [2:0] ST_DN2_E  = 3'd4;
  localparam logic [2:0] ST_UP3_E  = 3'd5;
  localparam logic [2:0] ST_DN3_E  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_E,
    ST_UP1  = ST_UP1_E,
    ST_DN1  = ST_DN1_E,
    ST_UP2  = ST_UP2_E,
    ST_DN2  = ST_DN2_E,
    ST_UP3  = ST_UP3_E,
    ST_DN3  = ST_DN3_E
  } state_t;

endpackage

// File: rtl/bf_lamp_checker.sv
// Compares the datapath lamp bus with the thermometer code of the next level; sticky error flag.
module bf_lamp_checker
  import bf_pkg::*;
#(
  parameter int NUM_LAMPS = NUM_LAMPS_DEF,
  parameter int LVL_W     = $clog2(NUM_LAMPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LVL_W-1:0]     level_nxt,
  input  logic [NUM_LAMPS-1:0] lamp,
  output logic                 lamp_err
);

  function automatic logic [NUM_LAMPS-1:0] therm(input logic [LVL_W-1:0] n);
    logic [NUM_LAMPS-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_LAMPS; i++) t[i] = (i < int'(n));
    return t;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         lamp_err <= 1'b0;
    else if (lamp != therm(level_nxt))  lamp_err <= 1'b1;
  end

endmodule

// File: rtl/bound_flasher_ctrl.sv
// Bound-flasher command sequencer for the lamp shift datapath.
// Define BOUND_FLASHER_LAMP_CHECK_EN to cross-check the lamp bus against the level counter.
module bound_flasher_ctrl
  import bf_pkg::*;
#(
  parameter int NUM_LAMPS = NUM_LAMPS_DEF,
  parameter int LVL_A     = 6,
  parameter int LVL_B     = 11,
  parameter int LVL_C     = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flick,
  input  logic [NUM_LAMPS-1:0]               lamp,
  output logic [1:0]                         cmd,
  output logic [$clog2(NUM_LAMPS+1)-1:0]     level,
  output logic                               busy,
  output logic                               lamp_err
);

  localparam int LVL_W = $clog2(NUM_LAMPS + 1);
  localparam logic [LVL_W-1:0] LV_A   = LVL_W'(LVL_A);
  localparam logic [LVL_W-1:0] LV_B   = LVL_W'(LVL_B);
  localparam logic [LVL_W-1:0] LV_C   = LVL_W'(LVL_C);
  localparam logic [LVL_W-1:0] LV_MAX = LVL_W'(NUM_LAMPS);

  state_t           state, state_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             kick;

  always_comb begin
    cmd = CMD_CLEAR;
    case (state)
      ST_UP1, ST_UP2, ST_UP3: cmd = CMD_ON;
      ST_DN1, ST_DN2, ST_DN3: cmd = CMD_OFF;
      default:                cmd = CMD_CLEAR;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Counter mirrors what the datapath will hold after this edge.
  always_comb begin
    level_nxt = '0;
    case (cmd)
      CMD_ON:  level_nxt = (level == LV_MAX) ? level : level + 1'b1;
      CMD_OFF: level_nxt = (level == '0)     ? level : level - 1'b1;
      default: level_nxt = '0;
    endcase
  end

  assign kick = flick && ((level_nxt == LV_A) || (level_nxt == LV_B));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (flick)                 state_nxt = ST_UP1;
      ST_UP1:  if (level_nxt == LV_A)     state_nxt = ST_DN1;
      ST_DN1:  if (level_nxt == '0)       state_nxt = ST_UP2;
      ST_UP2:  if (kick)                  state_nxt = ST_DN1;
               else if (level_nxt == LV_B) state_nxt = ST_DN2;
      ST_DN2:  if (level_nxt == LV_C)     state_nxt = ST_UP3;
      ST_UP3:  if (kick)                  state_nxt = ST_DN2;
               else if (level_nxt == LV_MAX) state_nxt = ST_DN3;
      ST_DN3:  if (level_nxt == '0)       state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      level <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

`ifdef BOUND_FLASHER_LAMP_CHECK_EN
  bf_lamp_checker #(
    .NUM_LAMPS (NUM_LAMPS),
    .LVL_W     (LVL_W)
  ) u_lamp_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .level_nxt (level_nxt),
    .lamp      (lamp),
    .lamp_err  (lamp_err)
  );
`else
  logic unused_lamp;
  assign unused_lamp = ^lamp;
  assign lamp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Randomized and directed bench for bound_flasher_ctrl against a phase/target behavioural model.
module tb_bound_flasher_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flick = 1'b0;
  logic [15:0] fault = 16'h0000;
  logic [15:0] lamp;
  logic [1:0]  cmd;
  logic [4:0]  level;
  logic        busy;
  logic        lamp_err;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, odd phases count up, even phases count down, each to a target level.
  int m_ph  = 0;
  int m_lvl = 0;
  int m_nxt;
  bit m_err = 1'b0;
  int pts[$];
  int exp_pts[$];

`ifdef BOUND_FLASHER_LAMP_CHECK_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  bound_flasher_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flick    (flick),
    .lamp     (lamp),
    .cmd      (cmd),
    .level    (level),
    .busy     (busy),
    .lamp_err (lamp_err)
  );

  always #5 clk = ~clk;

  function automatic int dir_of(input int ph);
    if (ph == 0) return 0;
    return (ph % 2 == 1) ? 1 : -1;
  endfunction

  function automatic int tgt_of(input int ph);
    case (ph)
      1: return 6;
      2: return 0;
      3: return 11;
      4: return 5;
      5: return 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] therm(input int n);
    return 16'((32'd1 << n) - 32'd1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  assign m_nxt = (m_ph == 0) ? 0 : m_lvl + dir_of(m_ph);
  assign lamp  = therm(m_nxt) & ~fault;

  always @(posedge clk or negedge rst_n) begin : model
    int ph;
    if (!rst_n) begin
      m_ph  <= 0;
      m_lvl <= 0;
      m_err <= 1'b0;
    end else begin
      ph = m_ph;
      if (m_ph == 0) begin
        if (flick) ph = 1;
      end else if ((m_ph == 3 || m_ph == 5) && flick && (m_nxt == 6 || m_nxt == 11)) begin
        ph = m_ph - 1;
      end else if (m_nxt == tgt_of(m_ph)) begin
        ph = (m_ph == 6) ? 0 : m_ph + 1;
      end
      m_ph  <= ph;
      m_lvl <= m_nxt;
      if (EXP_ERR && (lamp != therm(m_nxt))) m_err <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("cmd", int'(cmd), (dir_of(m_ph) > 0) ? 1 : ((dir_of(m_ph) < 0) ? 2 : 0));
      chk("level", int'(level), m_lvl);
      chk("busy", int'(busy), int'(m_ph != 0));
      chk("lamp_err", int'(lamp_err), int'(m_err));
    end
  end

  // One flick from IDLE; optional single kickback at (phase, level) and optional one-cycle lamp[3] fault.
  task automatic run_seq(input string tag, input int kick_ph, input int kick_lvl,
                         input bit do_fault, input int exp_busy);
    int  nbusy    = 0;
    int  cyc      = 0;
    int  prev_cmd = 0;
    bit  kicked   = 1'b0;
    bit  faulted  = 1'b0;
    pts.delete();
    flick = 1'b1;
    @(negedge clk);
    forever begin
      if (int'(cmd) != prev_cmd) begin
        pts.push_back(int'(level));
        prev_cmd = int'(cmd);
      end
      if (!busy || cyc >= 200) break;
      nbusy++;
      flick = !kicked && (m_ph == kick_ph) && (m_lvl == kick_lvl);
      if (flick) kicked = 1'b1;
      fault = (do_fault && !faulted && m_nxt == 8) ? 16'h0008 : 16'h0000;
      if (fault != 16'h0000) faulted = 1'b1;
      @(negedge clk);
      cyc++;
    end
    flick = 1'b0;
    fault = 16'h0000;
    chk({tag, " timeout"}, int'(cyc >= 200), 0);
    chk({tag, " busy_cycles"}, nbusy, exp_busy);
    chk({tag, " turn_points"}, pts.size(), exp_pts.size());
    for (int i = 0; i < exp_pts.size() && i < pts.size(); i++)
      chk($sformatf("%s point%0d", tag, i), pts[i], exp_pts[i]);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    chk("reset cmd", int'(cmd), 0);
    chk("reset level", int'(level), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset lamp_err", int'(lamp_err), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle cmd", int'(cmd), 0);
      chk("idle level", int'(level), 0);
      chk("idle busy", int'(busy), 0);
    end

    exp_pts = '{0, 6, 0, 11, 5, 16, 0};
    run_seq("single", -1, 0, 1'b0, 56);
    exp_pts = '{0, 6, 0, 6, 0, 11, 5, 16, 0};
    run_seq("kick_up2", 3, 5, 1'b0, 68);
    exp_pts = '{0, 6, 0, 11, 5, 11, 5, 16, 0};
    run_seq("kick_up3", 5, 10, 1'b0, 68);
    exp_pts = '{0, 6, 0, 11, 5, 16, 0};
    run_seq("lamp_fault", -1, 0, 1'b1, 56);
    chk("lamp_err sticky", int'(lamp_err), int'(EXP_ERR));

    flick = 1'b1;
    @(negedge clk);
    flick = 1'b0;
    cyc = 0;
    while (!(m_ph == 3 && m_lvl == 9) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach level 9 timeout", int'(cyc >= 200), 0);
    chk("pre-reset level", int'(level), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("async cmd", int'(cmd), 0);
    chk("async level", int'(level), 0);
    chk("async busy", int'(busy), 0);
    chk("async lamp_err", int'(lamp_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pts = '{0, 6, 0, 11, 5, 16, 0};
    run_seq("after_reset", -1, 0, 1'b0, 56);

    for (int i = 0; i < 1500; i++) begin
      flick = ($urandom_range(7) == 0);
      @(negedge clk);
    end
    flick = 1'b0;
    repeat (80) @(negedge clk);
    chk("final idle busy", int'(busy), 0);
    chk("final idle cmd", int'(cmd), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
